csr_file: RTL and testbench

Machine-mode control and status register file for the RV32IM core. It is the responder on the CSR port that the ALU drives during CSRRW/CSRRS/CSRRC and their immediate forms. The ALU presents a 12-bit address and receives the current CSR value combinationally. On the next rising edge this block commits the computed write data. It also owns the cycle and instret counters, trap entry and MRET state updates, and interrupt-pending generation for the control unit.

---
 rtl/csr_file.sv | 145 ++++++++++++++
 tb/tb_csr_file.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV32IM core: CSR read/write port, 64-bit cycle/instret
// counters, trap entry / MRET state and interrupt-pending generation.
module csr_file #(
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MISA_VAL    = 32'h4000_1100,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [11:0] i_csr_select,
  input  logic        i_csr_load,
  input  logic [31:0] i_csr_data,
  output logic [31:0] o_csr_reg,
  output logic        o_csr_illegal,
  input  logic        i_retire,
  input  logic        i_irq_ext,
  input  logic        i_irq_timer,
  input  logic        i_irq_sw,
  input  logic        i_trap,
  input  logic [31:0] i_trap_cause,
  input  logic [31:0] i_trap_pc,
  input  logic [31:0] i_trap_val,
  input  logic        i_mret,
  output logic [31:0] o_trap_vector,
  output logic [31:0] o_mepc,
  output logic        o_irq_pending
);
  localparam logic [11:0] A_MSTATUS = 12'h300, A_MISA = 12'h301, A_MIE = 12'h304,
                          A_MTVEC = 12'h305, A_MSCRATCH = 12'h340, A_MEPC = 12'h341,
                          A_MCAUSE = 12'h342, A_MTVAL = 12'h343, A_MIP = 12'h344,
                          A_MCYCLE = 12'hB00, A_MCYCLEH = 12'hB80, A_MINSTRET = 12'hB02,
                          A_MINSTRETH = 12'hB82, A_CYCLE = 12'hC00, A_CYCLEH = 12'hC80,
                          A_INSTRET = 12'hC02, A_INSTRETH = 12'hC82, A_MHARTID = 12'hF14;
  localparam logic [31:0] MIE_MASK = 32'h0000_0888;

  logic        r_mstat_mie, r_mstat_mpie;
  logic [31:0] r_mie_csr, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
  logic        r_ip_ext, r_ip_tim, r_ip_sw;
  logic [63:0] r_cycle, r_instret;

  logic [31:0] w_mstatus, w_mip, w_tvec_base;
  logic        w_known, w_ro, w_we;
  logic        w_unused;

  assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mstat_mpie, 3'b0, r_mstat_mie, 3'b0};
  assign w_mip     = {20'b0, r_ip_ext, 3'b0, r_ip_tim, 3'b0, r_ip_sw, 3'b0};
  assign w_unused  = i_trap_cause[30];

  always_comb begin
    o_csr_reg = 32'h0;
    w_known   = 1'b1;
    case (i_csr_select)
      A_MSTATUS:               o_csr_reg = w_mstatus;
      A_MISA:                  o_csr_reg = MISA_VAL;
      A_MIE:                   o_csr_reg = r_mie_csr;
      A_MTVEC:                 o_csr_reg = r_mtvec;
      A_MSCRATCH:              o_csr_reg = r_mscratch;
      A_MEPC:                  o_csr_reg = r_mepc;
      A_MCAUSE:                o_csr_reg = r_mcause;
      A_MTVAL:                 o_csr_reg = r_mtval;
      A_MIP:                   o_csr_reg = w_mip;
      A_MCYCLE, A_CYCLE:       o_csr_reg = r_cycle[31:0];
      A_MCYCLEH, A_CYCLEH:     o_csr_reg = r_cycle[63:32];
      A_MINSTRET, A_INSTRET:   o_csr_reg = r_instret[31:0];
      A_MINSTRETH, A_INSTRETH: o_csr_reg = r_instret[63:32];
      A_MHARTID:               o_csr_reg = HART_ID;
      default:                 w_known   = 1'b0;
    endcase
  end

  // misa and mip are read-only despite living in the read/write address range
  assign w_ro = (i_csr_select[11:10] == 2'b11) || (i_csr_select == A_MISA) ||
                (i_csr_select == A_MIP);
  assign o_csr_illegal = !w_known || (w_ro && i_csr_load);
  assign w_we = i_csr_load && w_known && !w_ro;

  assign w_tvec_base   = {r_mtvec[31:2], 2'b00};
  assign o_trap_vector = (r_mtvec[1:0] == 2'b00 || !i_trap_cause[31]) ? w_tvec_base
                         : w_tvec_base + {i_trap_cause[29:0], 2'b00};
  assign o_mepc        = r_mepc;
  assign o_irq_pending = r_mstat_mie && |(w_mip & r_mie_csr);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mstat_mie  <= 1'b0;
      r_mstat_mpie <= 1'b0;
      r_mie_csr    <= 32'h0;
      r_mtvec      <= MTVEC_RESET & ~32'h2;
      r_mscratch   <= 32'h0;
      r_mepc       <= 32'h0;
      r_mcause     <= 32'h0;
      r_mtval      <= 32'h0;
      r_ip_ext     <= 1'b0;
      r_ip_tim     <= 1'b0;
      r_ip_sw      <= 1'b0;
      r_cycle      <= 64'h0;
      r_instret    <= 64'h0;
    end else begin
      r_ip_ext <= i_irq_ext;
      r_ip_tim <= i_irq_timer;
      r_ip_sw  <= i_irq_sw;

      // Trap/MRET own the trap-state registers for this edge; software writes lose
      if (i_trap) begin
        r_mepc       <= i_trap_pc & ~32'h3;
        r_mcause     <= i_trap_cause;
        r_mtval      <= i_trap_val;
        r_mstat_mpie <= r_mstat_mie;
        r_mstat_mie  <= 1'b0;
      end else if (i_mret) begin
        r_mstat_mie  <= r_mstat_mpie;
        r_mstat_mpie <= 1'b1;
      end else if (w_we) begin
        case (i_csr_select)
          A_MSTATUS: begin
            r_mstat_mie  <= i_csr_data[3];
            r_mstat_mpie <= i_csr_data[7];
          end
          A_MEPC:   r_mepc   <= i_csr_data & ~32'h3;
          A_MCAUSE: r_mcause <= i_csr_data;
          A_MTVAL:  r_mtval  <= i_csr_data;
          default: ;
        endcase
      end

      if (w_we) begin
        case (i_csr_select)
          A_MIE:      r_mie_csr  <= i_csr_data & MIE_MASK;
          A_MTVEC:    r_mtvec    <= i_csr_data & ~32'h2;
          A_MSCRATCH: r_mscratch <= i_csr_data;
          default: ;
        endcase
      end

      // A write to either half replaces that half and suppresses the increment
      if (w_we && i_csr_select == A_MCYCLE)       r_cycle <= {r_cycle[63:32], i_csr_data};
      else if (w_we && i_csr_select == A_MCYCLEH) r_cycle <= {i_csr_data, r_cycle[31:0]};
      else                                        r_cycle <= r_cycle + 64'd1;

      if (w_we && i_csr_select == A_MINSTRET)       r_instret <= {r_instret[63:32], i_csr_data};
      else if (w_we && i_csr_select == A_MINSTRETH) r_instret <= {i_csr_data, r_instret[31:0]};
      else if (i_retire)                            r_instret <= r_instret + 64'd1;
    end
  end
endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file: reset values, masking, read-only handling, interrupts,
// trap/MRET, counter carry/wrap and event priority.
module tb_csr_file;
  logic        clk, rst_n;
  logic [11:0] sel;
  logic        load;
  logic [31:0] data;
  logic [31:0] rdata;
  logic        illegal;
  logic        retire, irq_ext, irq_timer, irq_sw;
  logic        trap, mret;
  logic [31:0] cause, tpc, tval;
  logic [31:0] tvec, mepc;
  logic        pending;

  int checks = 0;
  int errors = 0;

  csr_file dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_csr_select(sel), .i_csr_load(load), .i_csr_data(data),
    .o_csr_reg(rdata), .o_csr_illegal(illegal),
    .i_retire(retire), .i_irq_ext(irq_ext), .i_irq_timer(irq_timer), .i_irq_sw(irq_sw),
    .i_trap(trap), .i_trap_cause(cause), .i_trap_pc(tpc), .i_trap_val(tval),
    .i_mret(mret), .o_trap_vector(tvec), .o_mepc(mepc), .o_irq_pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-edge write: load is high across exactly one rising edge
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk); sel = a; data = d; load = 1'b1;
    @(negedge clk); load = 1'b0; #1;
  endtask

  task automatic rd(input logic [11:0] a);
    sel = a; load = 1'b0; #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; sel = 12'h300; load = 0; data = 0; retire = 0;
    irq_ext = 0; irq_timer = 0; irq_sw = 0; trap = 0; mret = 0;
    cause = 0; tpc = 0; tval = 0;
    #1;
    checks++; if (rdata !== 32'h0000_1800) begin errors++; $display("FAIL rst_mstatus: got %h exp %h", rdata, 32'h1800); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL rst_pending: got %b exp 0", pending); end
    checks++; if (mepc !== 32'h0) begin errors++; $display("FAIL rst_mepc: got %h exp 0", mepc); end
    checks++; if (tvec !== 32'h0) begin errors++; $display("FAIL rst_tvec: got %h exp 0", tvec); end
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(negedge clk); rd(12'hB00);
    checks++; if (rdata !== 32'd1) begin errors++; $display("FAIL rst_mcycle1: got %h exp 1", rdata); end
    rd(12'h301);
    checks++; if (rdata !== 32'h4000_1100) begin errors++; $display("FAIL misa: got %h exp %h", rdata, 32'h40001100); end
    rd(12'hF14);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mhartid: got %h exp 0", rdata); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL mhartid_ill: got %b exp 0", illegal); end
    rd(12'h7C0);
    checks++; if (rdata !== 32'h0 || illegal !== 1'b1) begin errors++; $display("FAIL unimpl: got %h/%b exp 0/1", rdata, illegal); end
  endtask

  task automatic test_masks;
    wr(12'h305, 32'hFFFF_FFFF); rd(12'h305);
    checks++; if (rdata !== 32'hFFFF_FFFD) begin errors++; $display("FAIL mtvec_mask: got %h exp fffffffd", rdata); end
    wr(12'h341, 32'hFFFF_FFFF); rd(12'h341);
    checks++; if (rdata !== 32'hFFFF_FFFC) begin errors++; $display("FAIL mepc_mask: got %h exp fffffffc", rdata); end
    wr(12'h300, 32'hFFFF_FFFF); rd(12'h300);
    checks++; if (rdata !== 32'h0000_1888) begin errors++; $display("FAIL mstatus_mask: got %h exp 1888", rdata); end
    wr(12'h304, 32'hFFFF_FFFF); rd(12'h304);
    checks++; if (rdata !== 32'h0000_0888) begin errors++; $display("FAIL mie_mask: got %h exp 888", rdata); end
    wr(12'h300, 32'h0); wr(12'h304, 32'h0);
    wr(12'h301, 32'h0); rd(12'h301);
    checks++; if (rdata !== 32'h4000_1100) begin errors++; $display("FAIL misa_ro: got %h exp 40001100", rdata); end
  endtask

  task automatic test_readonly;
    @(negedge clk); sel = 12'hB00; data = 32'd100; load = 1'b1;
    @(negedge clk); sel = 12'hC00; data = 32'h0; load = 1'b1; #1;
    checks++; if (rdata !== 32'd100) begin errors++; $display("FAIL cycle_alias: got %h exp 100", rdata); end
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ro_ill_load: got %b exp 1", illegal); end
    @(negedge clk); load = 1'b0; #1;
    checks++; if (rdata !== 32'd101) begin errors++; $display("FAIL ro_ignored: got %h exp 101", rdata); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ro_ill_idle: got %b exp 0", illegal); end
  endtask

  task automatic test_irq;
    wr(12'h300, 32'h8); wr(12'h304, 32'h800);
    @(negedge clk); irq_ext = 1'b1; #1;
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL irq_early: got %b exp 0", pending); end
    @(negedge clk); rd(12'h344);
    checks++; if (rdata !== 32'h800) begin errors++; $display("FAIL mip: got %h exp 800", rdata); end
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL irq_pend: got %b exp 1", pending); end
    wr(12'h300, 32'h0);
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL irq_mie_off: got %b exp 0", pending); end
    irq_ext = 1'b0; irq_timer = 1'b1;
    @(negedge clk); rd(12'h344);
    checks++; if (rdata !== 32'h080) begin errors++; $display("FAIL mip_timer: got %h exp 80", rdata); end
    irq_timer = 1'b0; wr(12'h304, 32'h0);
  endtask

  task automatic test_trap_mret;
    wr(12'h305, 32'h1001); wr(12'h300, 32'h8);
    @(negedge clk); trap = 1'b1; cause = 32'h8000_000B; tpc = 32'h1236; tval = 32'h55; #1;
    checks++; if (tvec !== 32'h102C) begin errors++; $display("FAIL tvec_vec: got %h exp 102c", tvec); end
    @(negedge clk); trap = 1'b0; rd(12'h300);
    checks++; if (rdata !== 32'h1880) begin errors++; $display("FAIL trap_mstatus: got %h exp 1880", rdata); end
    checks++; if (mepc !== 32'h1234) begin errors++; $display("FAIL trap_mepc: got %h exp 1234", mepc); end
    rd(12'h342);
    checks++; if (rdata !== 32'h8000_000B) begin errors++; $display("FAIL trap_mcause: got %h exp 8000000b", rdata); end
    rd(12'h343);
    checks++; if (rdata !== 32'h55) begin errors++; $display("FAIL trap_mtval: got %h exp 55", rdata); end
    cause = 32'h0000_000B; #1;
    checks++; if (tvec !== 32'h1000) begin errors++; $display("FAIL tvec_sync: got %h exp 1000", tvec); end
    @(negedge clk); mret = 1'b1;
    @(negedge clk); mret = 1'b0; rd(12'h300);
    checks++; if (rdata !== 32'h1888) begin errors++; $display("FAIL mret_mstatus: got %h exp 1888", rdata); end
    wr(12'h305, 32'h1000); cause = 32'h8000_000B; #1;
    checks++; if (tvec !== 32'h1000) begin errors++; $display("FAIL tvec_direct: got %h exp 1000", tvec); end
    wr(12'h300, 32'h0); cause = 32'h0;
  endtask

  task automatic test_counters;
    wr(12'hB80, 32'h0);
    @(negedge clk); sel = 12'hB00; data = 32'hFFFF_FFFF; load = 1'b1;
    @(negedge clk); load = 1'b0; rd(12'hB00);
    checks++; if (rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cyc_lo_wr: got %h exp ffffffff", rdata); end
    @(negedge clk); rd(12'hB80);
    checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL cyc_carry_hi: got %h exp 1", rdata); end
    rd(12'hB00);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL cyc_carry_lo: got %h exp 0", rdata); end
    @(negedge clk); sel = 12'hB00; data = 32'hFFFF_FFFF; load = 1'b1;
    @(negedge clk); sel = 12'hB80; data = 32'h77; load = 1'b1;
    @(negedge clk); load = 1'b0; rd(12'hB80);
    checks++; if (rdata !== 32'h77) begin errors++; $display("FAIL cyc_hi_nocarry: got %h exp 77", rdata); end
    rd(12'hB00);
    checks++; if (rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cyc_lo_hold: got %h exp ffffffff", rdata); end
    @(negedge clk); rd(12'hC80);
    checks++; if (rdata !== 32'h78) begin errors++; $display("FAIL cyc_next_hi: got %h exp 78", rdata); end
    @(negedge clk); sel = 12'hB80; data = 32'hFFFF_FFFF; load = 1'b1;
    @(negedge clk); sel = 12'hB00; data = 32'hFFFF_FFFF; load = 1'b1;
    @(negedge clk); load = 1'b0; rd(12'hB80);
    @(negedge clk); rd(12'hB80);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL cyc_wrap_hi: got %h exp 0", rdata); end
    rd(12'hB00);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL cyc_wrap_lo: got %h exp 0", rdata); end
    @(negedge clk); sel = 12'hB02; data = 32'd5; load = 1'b1; retire = 1'b1;
    @(negedge clk); load = 1'b0;
    @(negedge clk);
    @(negedge clk); retire = 1'b0; rd(12'hC02);
    checks++; if (rdata !== 32'd7) begin errors++; $display("FAIL instret: got %h exp 7", rdata); end
  endtask

  task automatic test_priority;
    wr(12'h340, 32'h0);
    @(negedge clk); sel = 12'h342; data = 32'h1234_5678; load = 1'b1;
    trap = 1'b1; cause = 32'h7; tpc = 32'h100; tval = 32'h0;
    @(negedge clk); trap = 1'b0; rd(12'h342);
    checks++; if (rdata !== 32'h7) begin errors++; $display("FAIL prio_mcause: got %h exp 7", rdata); end
    @(negedge clk); sel = 12'h340; data = 32'hA5A5; load = 1'b1; trap = 1'b1; cause = 32'h3;
    @(negedge clk); trap = 1'b0; rd(12'h340);
    checks++; if (rdata !== 32'hA5A5) begin errors++; $display("FAIL prio_mscratch: got %h exp a5a5", rdata); end
    rd(12'h342);
    checks++; if (rdata !== 32'h3) begin errors++; $display("FAIL prio_mcause2: got %h exp 3", rdata); end
    @(negedge clk); sel = 12'h341; data = 32'h8888; load = 1'b1; mret = 1'b1;
    @(negedge clk); mret = 1'b0; load = 1'b0; #1;
    checks++; if (mepc !== 32'h100) begin errors++; $display("FAIL prio_mret_mepc: got %h exp 100", mepc); end
    cause = 32'h0;
  endtask

  task automatic test_reset_midop;
    @(negedge clk); sel = 12'h340; data = 32'hDEAD; load = 1'b1;
    #2 rst_n = 1'b0; #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL midrst_async: got %h exp 0", rdata); end
    @(negedge clk); load = 1'b0; rst_n = 1'b1; rd(12'h340);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL midrst_discard: got %h exp 0", rdata); end
    @(negedge clk); rd(12'hB00);
    checks++; if (rdata !== 32'd1) begin errors++; $display("FAIL midrst_mcycle: got %h exp 1", rdata); end
  endtask

  initial begin
    test_reset;
    test_masks;
    test_readonly;
    test_irq;
    test_trap_mret;
    test_counters;
    test_priority;
    test_reset_midop;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
